gs_cfg_sequencer: RTL and testbench

//  Synchronous, parametrised FPGA configuration sequencer and reset controller for NeoGS.

---
 rtl/gs_cfg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_gs_cfg_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gs_cfg_sequencer.sv
// NeoGS FPGA configuration sequencer and reset controller: drives nCONFIG, watches the
// ACEX1K status pins with timeout and retry, and owns the memcfg paging register.
module gs_cfg_sequencer #(
  parameter int unsigned PAGE_W    = 1,
  parameter int unsigned PULSE_CYC = 8,
  parameter int unsigned TMO_W     = 16,
  parameter int unsigned RETRIES   = 2,
  parameter int unsigned RST_W     = 4,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic              clkin,
  input  logic              coldres,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [1:0]        port_sel,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              config_n,
  input  logic              status_n,
  input  logic              conf_done,
  input  logic              init_done,
  output logic              disbl,
  output logic              warmres_n,
  output logic              was_cold_reset_n,
  output logic              mem_ram,
  output logic [PAGE_W-1:0] mem_page,
  output logic              cfg_error
);

  localparam int unsigned CntW = (TMO_W > $clog2(PULSE_CYC)) ? TMO_W : $clog2(PULSE_CYC);
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYC - 1);
  // Last WAIT_ST count value; the timeout fires after 2**TMO_W-1 cycles in WAIT_ST.
  localparam logic [CntW-1:0] TmoLast   = CntW'((2 ** TMO_W) - 2);

  typedef enum logic [2:0] {StPulse, StWaitSt, StLoad, StInit, StDone, StError} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          retry_q, retry_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [SYNC_STG-1:0] st_sync_q, cd_sync_q, id_sync_q;
  logic                init_prev_q;
  logic                config_n_q, disbl_q, warmres_n_q, was_cold_q, mem_ram_q, cfg_error_q;
  logic [PAGE_W-1:0]   mem_page_q;
  logic [7:0]          rdata_q, rd_val;

  logic status_n_s, conf_done_s, init_done_s, init_rise;
  logic wr_p01, wr_p10, trigger, done_entry;
  logic unused_wdata;

  assign status_n_s  = st_sync_q[SYNC_STG-1];
  assign conf_done_s = cd_sync_q[SYNC_STG-1];
  assign init_done_s = id_sync_q[SYNC_STG-1];
  assign init_rise   = init_done_s && !init_prev_q;

  assign wr_p01     = io_wr && (port_sel == 2'b01);
  assign wr_p10     = io_wr && (port_sel == 2'b10);
  assign trigger    = wr_p10 && !wdata[0];
  assign done_entry = (state_d == StDone) && !disbl_q;
  assign unused_wdata = ^wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      StPulse: begin
        if (cnt_q == PulseLast) begin
          state_d = StWaitSt;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitSt: begin
        if (status_n_s) begin
          state_d = StLoad;
        end else if (cnt_q == TmoLast) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLoad, StInit: begin
        if (!status_n_s) begin
          if (retry_q < 3'(RETRIES)) begin
            state_d = StPulse;
            cnt_d   = '0;
            retry_d = retry_q + 3'd1;
          end else begin
            state_d = StError;
          end
        end else if ((state_q == StLoad) && conf_done_s) begin
          state_d = StInit;
        end else if ((state_q == StInit) && init_rise) begin
          state_d = StDone;
        end
      end
      StDone, StError: ;
      default: begin
        state_d = StPulse;
        cnt_d   = '0;
      end
    endcase
    // Host trigger overrides whatever the FSM decided, including mid-pulse restart.
    if (trigger) begin
      state_d = StPulse;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (done_entry) begin
      rst_cnt_d = '1;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - RST_W'(1);
    end
  end

  always_comb begin
    rd_val = '0;
    case (port_sel)
      2'b01:   rd_val = {was_cold_q, 7'b0};
      2'b10:   rd_val = {status_n_s, cfg_error_q, disbl_q, retry_q, init_done_s, conf_done_s};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      state_q     <= StPulse;
      cnt_q       <= '0;
      retry_q     <= '0;
      rst_cnt_q   <= '1;
      st_sync_q   <= '0;
      cd_sync_q   <= '0;
      id_sync_q   <= '0;
      init_prev_q <= 1'b0;
      config_n_q  <= 1'b0;
      disbl_q     <= 1'b0;
      warmres_n_q <= 1'b0;
      was_cold_q  <= 1'b0;
      mem_ram_q   <= 1'b0;
      mem_page_q  <= '0;
      cfg_error_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      rst_cnt_q   <= rst_cnt_d;
      st_sync_q   <= {st_sync_q[SYNC_STG-2:0], status_n};
      cd_sync_q   <= {cd_sync_q[SYNC_STG-2:0], conf_done};
      id_sync_q   <= {id_sync_q[SYNC_STG-2:0], init_done};
      init_prev_q <= init_done_s;
      config_n_q  <= (state_d != StPulse);
      disbl_q     <= (state_d == StDone);
      cfg_error_q <= (state_d == StError);
      // Registered off the pre-update count so the low phase spans the full 2**RST_W cycles.
      warmres_n_q <= !done_entry && (rst_cnt_q == '0);
      if (wr_p10 && wdata[7]) begin
        was_cold_q <= 1'b1;
      end
      if (wr_p01) begin
        mem_ram_q  <= wdata[7];
        mem_page_q <= wdata[PAGE_W-1:0];
      end
      if (io_rd) begin
        rdata_q <= rd_val;
      end
    end
  end

  assign rdata            = rdata_q;
  assign config_n         = config_n_q;
  assign disbl            = disbl_q;
  assign warmres_n        = warmres_n_q;
  assign was_cold_reset_n = was_cold_q;
  assign mem_ram          = mem_ram_q;
  assign mem_page         = mem_page_q;
  assign cfg_error        = cfg_error_q;

endmodule

// File: tb/tb_gs_cfg_sequencer.sv
// Directed bench for gs_cfg_sequencer: configuration flow, timeout, retries, host ports,
// warm reset timing and asynchronous cold reset.
module tb_gs_cfg_sequencer;

  logic       clkin = 1'b0;
  logic       coldres = 1'b1;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [1:0] port_sel = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       status_n = 1'b0;
  logic       conf_done = 1'b0;
  logic       init_done = 1'b0;
  logic [7:0] rdata;
  logic       config_n, disbl, warmres_n, was_cold_reset_n, mem_ram, cfg_error;
  logic [0:0] mem_page;

  int n_vec = 0;
  int n_miss = 0;

  gs_cfg_sequencer #(
    .PAGE_W   (1),
    .PULSE_CYC(8),
    .TMO_W    (4),
    .RETRIES  (2),
    .RST_W    (4),
    .SYNC_STG (2)
  ) u_dut (
    .clkin           (clkin),
    .coldres         (coldres),
    .io_wr           (io_wr),
    .io_rd           (io_rd),
    .port_sel        (port_sel),
    .wdata           (wdata),
    .rdata           (rdata),
    .config_n        (config_n),
    .status_n        (status_n),
    .conf_done       (conf_done),
    .init_done       (init_done),
    .disbl           (disbl),
    .warmres_n       (warmres_n),
    .was_cold_reset_n(was_cold_reset_n),
    .mem_ram         (mem_ram),
    .mem_page        (mem_page),
    .cfg_error       (cfg_error)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] p, input logic [7:0] d);
    port_sel = p;
    wdata    = d;
    io_wr    = 1'b1;
    tick();
    io_wr    = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] p);
    port_sel = p;
    io_rd    = 1'b1;
    tick();
    io_rd    = 1'b0;
  endtask

  // Counts cycles until config_n reaches want; gives up at 100.
  task automatic wait_cfg(input logic want, output int n);
    n = 0;
    while (config_n !== want && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int cfg_hi, warm_hi1, disbl_on, warm_lo2, warm_hi2, n;

    // Reset values
    tick();
    tick();
    chk("rst config_n", config_n, 0);
    chk("rst disbl", disbl, 0);
    chk("rst warmres_n", warmres_n, 0);
    chk("rst was_cold", was_cold_reset_n, 0);
    chk("rst mem_ram", mem_ram, 0);
    chk("rst mem_page", mem_page, 0);
    chk("rst cfg_error", cfg_error, 0);
    chk("rst rdata", rdata, 0);

    // Test 1: normal configuration after cold reset
    coldres = 1'b0;
    cfg_hi = 0; warm_hi1 = 0; disbl_on = 0; warm_lo2 = 0; warm_hi2 = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (cfg_hi == 0 && config_n === 1'b1) cfg_hi = k;
      if (warm_hi1 == 0 && warmres_n === 1'b1) warm_hi1 = k;
      if (disbl_on == 0 && disbl === 1'b1) disbl_on = k;
      if (warm_hi1 != 0 && warm_lo2 == 0 && warmres_n === 1'b0) warm_lo2 = k;
      if (warm_lo2 != 0 && warm_hi2 == 0 && warmres_n === 1'b1) warm_hi2 = k;
      if (k == 10) begin
        status_n  = 1'b1;
        conf_done = 1'b1;
      end
      if (k == 20) init_done = 1'b1;
    end
    chk("t1 nconfig low cycles", cfg_hi, 8);
    chk("t1 cold warmres release", warm_hi1, 16);
    chk("t1 disbl rise", disbl_on, 23);
    chk("t1 warmres reload", warm_lo2, 23);
    chk("t1 warmres low length", warm_hi2 - warm_lo2, 16);
    chk("t1 cfg_error", cfg_error, 0);
    host_rd(2'b10);
    chk("t1 port10 read", rdata, 8'hA3);
    host_rd(2'b01);
    chk("t1 port01 read pre-ack", rdata, 8'h00);
    host_rd(2'b10);
    host_wr(2'b11, 8'h00);
    chk("t1 port11 write ignored", disbl, 1);
    host_wr(2'b10, 8'h01);
    chk("t1 no-trigger write disbl", disbl, 1);
    chk("t1 no-trigger write was_cold", was_cold_reset_n, 0);
    host_rd(2'b00);
    chk("t1 port00 read", rdata, 8'h00);

    // Test 4: trigger from DONE with simultaneous read of port 10
    port_sel = 2'b10;
    wdata    = 8'h80;
    io_wr    = 1'b1;
    io_rd    = 1'b1;
    tick();
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    chk("t4 disbl", disbl, 0);
    chk("t4 config_n", config_n, 0);
    chk("t4 was_cold", was_cold_reset_n, 1);
    chk("t4 cfg_error", cfg_error, 0);
    chk("t4 rd pre-write", rdata, 8'hA3);

    // Test 5: memcfg port
    host_wr(2'b01, 8'h81);
    chk("t5 mem_ram", mem_ram, 1);
    chk("t5 mem_page", mem_page, 1);
    host_rd(2'b01);
    chk("t5 port01 read", rdata, 8'h80);

    // Test 2: nSTATUS never released -> timeout
    status_n  = 1'b0;
    conf_done = 1'b0;
    init_done = 1'b0;
    host_wr(2'b10, 8'h00);
    n = 0;
    while (cfg_error !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t2 timeout cycles", n, 23);
    chk("t2 config_n", config_n, 1);
    host_rd(2'b10);
    chk("t2 port10 read", rdata, 8'h40);

    // Test 3: nSTATUS errors during LOAD exhaust retries
    status_n = 1'b1;
    host_wr(2'b10, 8'h00);
    wait_cfg(1'b1, n);
    chk("t3 pulse0 length", n, 8);
    for (int a = 1; a <= 2; a++) begin
      tick();
      tick();
      status_n = 1'b0;
      wait_cfg(1'b0, n);
      chk($sformatf("t3 drop%0d latency", a), n, 3);
      status_n = 1'b1;
      wait_cfg(1'b1, n);
      chk($sformatf("t3 pulse%0d length", a), n, 8);
    end
    tick();
    tick();
    status_n = 1'b0;
    n = 0;
    while (cfg_error !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("t3 error latency", n, 3);
    chk("t3 config_n", config_n, 1);
    host_rd(2'b10);
    chk("t3 port10 read", rdata, 8'h48);

    // Test 6: cold reset mid-LOAD
    status_n = 1'b1;
    host_wr(2'b01, 8'h81);
    host_wr(2'b10, 8'h00);
    wait_cfg(1'b1, n);
    chk("t6 pulse length", n, 8);
    tick();
    tick();
    coldres = 1'b1;
    #1;
    chk("t6 config_n", config_n, 0);
    chk("t6 disbl", disbl, 0);
    chk("t6 warmres_n", warmres_n, 0);
    chk("t6 was_cold", was_cold_reset_n, 0);
    chk("t6 mem_ram", mem_ram, 0);
    chk("t6 mem_page", mem_page, 0);
    chk("t6 cfg_error", cfg_error, 0);
    chk("t6 rdata", rdata, 8'h00);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
